// File: rtl/lsq_pkg.sv
// Shared types and widths for the LSQ / Dcache port slice.
// Arbiter state, address compare granularity and store buffer entry layout.
package lsq_pkg;

  typedef enum logic {
    LOAD_PRI,
    STORE_DRAIN
  } arb_state_t;

  localparam int ADDR_CMP_LSB = 3;
  localparam int DC_ADDR_W    = 64;
  localparam int DC_DATA_W    = 64;
  localparam int PR_W         = 7;
  localparam int AR_W         = 5;
  localparam int TAG_W        = DC_ADDR_W - ADDR_CMP_LSB;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_DATA_W-1:0] value;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Post-retire store buffer: circular FIFO, 2-wide push, 1 pop,
// plus a parallel 8-byte address match across all valid entries.
module sb_fifo
  import lsq_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int SB_BITS  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         push_num_i,
  input  sb_entry_t          push0_i,
  input  sb_entry_t          push1_i,
  input  logic               pop_i,
  input  logic [TAG_W-1:0]   cmp_tag_i,
  output sb_entry_t          head_o,
  output logic [SB_BITS:0]   count_o,
  output logic               match_any_o
);

  sb_entry_t           mem_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] vld_q;
  logic [SB_BITS-1:0]  head_q;
  logic [SB_BITS-1:0]  tail_q;
  logic [SB_BITS-1:0]  tail_p1;
  logic [SB_BITS:0]    count_q;

  assign tail_p1 = tail_q + 1'b1;
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop_i) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (push_num_i != 2'd0) begin
        mem_q[tail_q] <= push0_i;
        vld_q[tail_q] <= 1'b1;
      end
      if (push_num_i == 2'd2) begin
        mem_q[tail_p1] <= push1_i;
        vld_q[tail_p1] <= 1'b1;
      end
      tail_q  <= tail_q + SB_BITS'(push_num_i);
      count_q <= count_q
               + (SB_BITS+1)'(push_num_i)
               - (SB_BITS+1)'(pop_i);
    end
  end

  always_comb begin
    match_any_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (vld_q[i] &&
          mem_q[i].addr[DC_ADDR_W-1:ADDR_CMP_LSB] == cmp_tag_i)
        match_any_o = 1'b1;
    end
  end

endmodule

// File: rtl/dcache_port_arb.sv
// Dcache port arbiter: one load slot vs. a post-retire store buffer,
// with same-8-byte blocking and a bounded load-priority window.
module dcache_port_arb
  import lsq_pkg::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int SB_BITS    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lsq_rd_mem,
  input  logic [DC_ADDR_W-1:0] lsq_addr,
  input  logic [PR_W-1:0]      lsq_pr_idx,
  input  logic [AR_W-1:0]      lsq_ar_idx,
  output logic                 lsq_dcache_avail,
  input  logic [1:0]           rob_st_retire_num,
  input  logic [DC_ADDR_W-1:0] st_addr0,
  input  logic [DC_DATA_W-1:0] st_value0,
  input  logic [DC_ADDR_W-1:0] st_addr1,
  input  logic [DC_DATA_W-1:0] st_value1,
  output logic [1:0]           sb_free,
  output logic                 sb_overflow,
  output logic                 dc_req_valid,
  output logic                 dc_req_wr,
  output logic [DC_ADDR_W-1:0] dc_req_addr,
  output logic [DC_DATA_W-1:0] dc_req_value,
  output logic [PR_W-1:0]      dc_req_pr_idx,
  output logic [AR_W-1:0]      dc_req_ar_idx,
  input  logic                 dc_req_ready
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SB_BITS:0] DEPTH_C = (SB_BITS+1)'(SB_DEPTH);
  localparam logic [SW-1:0]    SMAX    = SW'(STARVE_MAX);

  arb_state_t           state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 ovf_q;
  logic                 slot_vld_q;
  logic [DC_ADDR_W-1:0] slot_addr_q;
  logic [PR_W-1:0]      slot_pr_q;
  logic [AR_W-1:0]      slot_ar_q;

  sb_entry_t        head;
  sb_entry_t        push0, push1;
  logic [SB_BITS:0] count, space;
  logic [1:0]       push_num;
  logic             ovf_hit, match, conflict, sb_empty;
  logic             gnt_ld, gnt_st, ld_xfer, st_xfer;

  assign space    = DEPTH_C - count;
  assign sb_free  = (space > (SB_BITS+1)'(1)) ? 2'd2 : space[1:0];
  assign ovf_hit  = rob_st_retire_num > sb_free;
  assign push_num = ovf_hit ? sb_free : rob_st_retire_num;
  assign push0    = '{addr: st_addr0, value: st_value0};
  assign push1    = '{addr: st_addr1, value: st_value1};
  assign sb_empty = (count == '0);
  assign conflict = slot_vld_q & match;
  assign ld_xfer  = gnt_ld & dc_req_ready;
  assign st_xfer  = gnt_st & dc_req_ready;

  assign lsq_dcache_avail = ~slot_vld_q;
  assign sb_overflow      = ovf_q;

  sb_fifo #(
    .SB_DEPTH (SB_DEPTH),
    .SB_BITS  (SB_BITS)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .push_num_i  (push_num),
    .push0_i     (push0),
    .push1_i     (push1),
    .pop_i       (st_xfer),
    .cmp_tag_i   (slot_addr_q[DC_ADDR_W-1:ADDR_CMP_LSB]),
    .head_o      (head),
    .count_o     (count),
    .match_any_o (match)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD_PRI;
      starve_q    <= '0;
      ovf_q       <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      slot_pr_q   <= '0;
      slot_ar_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ovf_q    <= ovf_q | ovf_hit;
      if (lsq_rd_mem && !slot_vld_q) begin
        slot_vld_q  <= 1'b1;
        slot_addr_q <= lsq_addr;
        slot_pr_q   <= lsq_pr_idx;
        slot_ar_q   <= lsq_ar_idx;
      end else if (ld_xfer) begin
        slot_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      LOAD_PRI: begin
        // a store slipping through in a gap breaks the load streak
        if (st_xfer)
          starve_d = '0;
        else if (ld_xfer && !sb_empty && starve_q != SMAX)
          starve_d = starve_q + 1'b1;
        if (count == DEPTH_C || starve_q == SMAX || conflict)
          state_d = STORE_DRAIN;
      end
      STORE_DRAIN: begin
        if (sb_empty ||
            (st_xfer && count == (SB_BITS+1)'(1) && push_num == 2'd0)) begin
          state_d  = LOAD_PRI;
          starve_d = '0;
        end
      end
      default: state_d = LOAD_PRI;
    endcase
  end

  always_comb begin
    gnt_ld        = (state_q == LOAD_PRI) & slot_vld_q & ~conflict;
    gnt_st        = ~gnt_ld & ~sb_empty;
    dc_req_valid  = gnt_ld | gnt_st;
    dc_req_wr     = gnt_st;
    dc_req_addr   = '0;
    dc_req_value  = '0;
    dc_req_pr_idx = '0;
    dc_req_ar_idx = '0;
    if (gnt_ld) begin
      dc_req_addr   = slot_addr_q;
      dc_req_pr_idx = slot_pr_q;
      dc_req_ar_idx = slot_ar_q;
    end else if (gnt_st) begin
      dc_req_addr  = head.addr;
      dc_req_value = head.value;
    end
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
// Directed vector bench for dcache_port_arb: table of per-cycle
// inputs/expected outputs plus hand-written multi-cycle sequences.
module tb_dcache_port_arb;

  logic        clock;
  logic        reset;
  logic        lsq_rd_mem;
  logic [63:0] lsq_addr;
  logic [6:0]  lsq_pr_idx;
  logic [4:0]  lsq_ar_idx;
  logic        lsq_dcache_avail;
  logic [1:0]  rob_st_retire_num;
  logic [63:0] st_addr0, st_value0;
  logic [63:0] st_addr1, st_value1;
  logic [1:0]  sb_free;
  logic        sb_overflow;
  logic        dc_req_valid;
  logic        dc_req_wr;
  logic [63:0] dc_req_addr;
  logic [63:0] dc_req_value;
  logic [6:0]  dc_req_pr_idx;
  logic [4:0]  dc_req_ar_idx;
  logic        dc_req_ready;

  int n_chk = 0;
  int n_err = 0;

  dcache_port_arb dut (
    .clock             (clock),
    .reset             (reset),
    .lsq_rd_mem        (lsq_rd_mem),
    .lsq_addr          (lsq_addr),
    .lsq_pr_idx        (lsq_pr_idx),
    .lsq_ar_idx        (lsq_ar_idx),
    .lsq_dcache_avail  (lsq_dcache_avail),
    .rob_st_retire_num (rob_st_retire_num),
    .st_addr0          (st_addr0),
    .st_value0         (st_value0),
    .st_addr1          (st_addr1),
    .st_value1         (st_value1),
    .sb_free           (sb_free),
    .sb_overflow       (sb_overflow),
    .dc_req_valid      (dc_req_valid),
    .dc_req_wr         (dc_req_wr),
    .dc_req_addr       (dc_req_addr),
    .dc_req_value      (dc_req_value),
    .dc_req_pr_idx     (dc_req_pr_idx),
    .dc_req_ar_idx     (dc_req_ar_idx),
    .dc_req_ready      (dc_req_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic [63:0] la;
    logic [6:0]  pr;
    logic [4:0]  ar;
    logic [1:0]  rn;
    logic [63:0] a0, v0, a1, v1;
    logic        rdy;
    logic        ev, ew;
    logic [63:0] ea, ed;
    logic [6:0]  ep;
    logic [4:0]  eq;
    logic        eav;
    logic [1:0]  ef;
    logic        eo;
  } vec_t;

  function automatic vec_t V(
    logic rd, logic [63:0] la, logic [6:0] pr, logic [4:0] ar,
    logic [1:0] rn, logic [63:0] a0, logic [63:0] v0,
    logic [63:0] a1, logic [63:0] v1, logic rdy,
    logic ev, logic ew, logic [63:0] ea, logic [63:0] ed,
    logic [6:0] ep, logic [4:0] eq,
    logic eav, logic [1:0] ef, logic eo);
    vec_t v;
    v.rd = rd; v.la = la; v.pr = pr; v.ar = ar;
    v.rn = rn; v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1;
    v.rdy = rdy; v.ev = ev; v.ew = ew; v.ea = ea; v.ed = ed;
    v.ep = ep; v.eq = eq; v.eav = eav; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(string t, vec_t v);
    chk({t, " valid"}, 64'(dc_req_valid), 64'(v.ev));
    chk({t, " wr"},    64'(dc_req_wr),    64'(v.ew));
    chk({t, " addr"},  dc_req_addr,       v.ea);
    chk({t, " value"}, dc_req_value,      v.ed);
    chk({t, " pr"},    64'(dc_req_pr_idx), 64'(v.ep));
    chk({t, " ar"},    64'(dc_req_ar_idx), 64'(v.eq));
    chk({t, " avail"}, 64'(lsq_dcache_avail), 64'(v.eav));
    chk({t, " free"},  64'(sb_free),      64'(v.ef));
    chk({t, " ovf"},   64'(sb_overflow),  64'(v.eo));
  endtask

  // drive at posedge+1, check at negedge, then advance one cycle
  task automatic cyc(string t, vec_t v);
    lsq_rd_mem        = v.rd;
    lsq_addr          = v.la;
    lsq_pr_idx        = v.pr;
    lsq_ar_idx        = v.ar;
    rob_st_retire_num = v.rn;
    st_addr0          = v.a0;
    st_value0         = v.v0;
    st_addr1          = v.a1;
    st_value1         = v.v1;
    dc_req_ready      = v.rdy;
    @(negedge clock);
    check_out(t, v);
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[19];
  vec_t idle_exp;

  initial begin
    reset = 1'b0;
    lsq_rd_mem = 0; lsq_addr = 0; lsq_pr_idx = 0; lsq_ar_idx = 0;
    rob_st_retire_num = 0;
    st_addr0 = 0; st_value0 = 0; st_addr1 = 0; st_value1 = 0;
    dc_req_ready = 0;
    idle_exp = V(0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0, 1,2,0);

    #1;
    check_out("rst0", idle_exp);
    repeat (3) @(posedge clock);
    #1;
    check_out("rst3", idle_exp);
    reset = 1'b1;
    cyc("rel", idle_exp);

    // load, conflict stall, full SB drain, back to load priority
    tbl[0]  = V(1,'h1000,12,3, 0,0,0,0,0, 1, 0,0,0,0,0,0, 1,2,0);
    tbl[1]  = V(0,0,0,0, 0,0,0,0,0, 1, 1,0,'h1000,0,12,3, 0,2,0);
    tbl[2]  = V(0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0, 1,2,0);
    tbl[3]  = V(0,0,0,0, 1,'h2008,'hAB,0,0, 0,
                0,0,0,0,0,0, 1,2,0);
    tbl[4]  = V(1,'h200C,5,1, 0,0,0,0,0, 0,
                1,1,'h2008,'hAB,0,0, 1,2,0);
    tbl[5]  = V(0,0,0,0, 0,0,0,0,0, 0, 1,1,'h2008,'hAB,0,0, 0,2,0);
    tbl[6]  = V(0,0,0,0, 0,0,0,0,0, 1, 1,1,'h2008,'hAB,0,0, 0,2,0);
    tbl[7]  = V(0,0,0,0, 0,0,0,0,0, 1, 1,0,'h200C,0,5,1, 0,2,0);
    tbl[8]  = V(0,0,0,0, 0,0,0,0,0, 1, 0,0,0,0,0,0, 1,2,0);
    tbl[9]  = V(0,0,0,0, 2,'h3000,'h11,'h3008,'h22, 0,
                0,0,0,0,0,0, 1,2,0);
    tbl[10] = V(0,0,0,0, 2,'h3010,'h33,'h3018,'h44, 0,
                1,1,'h3000,'h11,0,0, 1,2,0);
    tbl[11] = V(0,0,0,0, 0,0,0,0,0, 0, 1,1,'h3000,'h11,0,0, 1,0,0);
    tbl[12] = V(0,0,0,0, 0,0,0,0,0, 1, 1,1,'h3000,'h11,0,0, 1,0,0);
    tbl[13] = V(0,0,0,0, 0,0,0,0,0, 1, 1,1,'h3008,'h22,0,0, 1,1,0);
    tbl[14] = V(0,0,0,0, 0,0,0,0,0, 1, 1,1,'h3010,'h33,0,0, 1,2,0);
    tbl[15] = V(0,0,0,0, 0,0,0,0,0, 1, 1,1,'h3018,'h44,0,0, 1,2,0);
    tbl[16] = V(1,'h4000,7,2, 0,0,0,0,0, 1, 0,0,0,0,0,0, 1,2,0);
    tbl[17] = V(0,0,0,0, 0,0,0,0,0, 1, 1,0,'h4000,0,7,2, 0,2,0);
    tbl[18] = V(0,0,0,0, 0,0,0,0,0, 1, 0,0,0,0,0,0, 1,2,0);
    for (int i = 0; i < 19; i++)
      cyc($sformatf("v%0d", i), tbl[i]);

    // starvation: one buffered store, loads win while gaps are refused
    cyc("stv_push", V(0,0,0,0, 1,'h5000,'h55,0,0, 0,
                      0,0,0,0,0,0, 1,2,0));
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("stv%0d_gap", i),
          V(1,64'h6000 + 64'(8*i),7'(i),5'(i), 0,0,0,0,0, 0,
            1,1,'h5000,'h55,0,0, 1,2,0));
      cyc($sformatf("stv%0d_ld", i),
          V(0,0,0,0, 0,0,0,0,0, 1,
            1,0,64'h6000 + 64'(8*i),0,7'(i),5'(i), 0,2,0));
    end
    cyc("stv_gap8", V(1,'h6040,9,9, 0,0,0,0,0, 0,
                      1,1,'h5000,'h55,0,0, 1,2,0));
    cyc("stv_st",   V(0,0,0,0, 0,0,0,0,0, 1,
                      1,1,'h5000,'h55,0,0, 0,2,0));
    cyc("stv_ld9",  V(0,0,0,0, 0,0,0,0,0, 1,
                      1,0,'h6040,0,9,9, 0,2,0));

    // overflow: retire 2 with one free entry
    cyc("ovf0", V(0,0,0,0, 2,'h7000,1,'h7008,2, 0,
                  0,0,0,0,0,0, 1,2,0));
    cyc("ovf1", V(0,0,0,0, 1,'h7010,3,0,0, 0,
                  1,1,'h7000,1,0,0, 1,2,0));
    cyc("ovf2", V(0,0,0,0, 2,'h7018,4,'h7020,5, 0,
                  1,1,'h7000,1,0,0, 1,1,0));
    cyc("ovf3", V(0,0,0,0, 0,0,0,0,0, 0,
                  1,1,'h7000,1,0,0, 1,0,1));
    cyc("ovf4", V(0,0,0,0, 0,0,0,0,0, 1,
                  1,1,'h7000,1,0,0, 1,0,1));
    cyc("ovf5", V(0,0,0,0, 0,0,0,0,0, 1,
                  1,1,'h7008,2,0,0, 1,1,1));
    cyc("ovf6", V(0,0,0,0, 0,0,0,0,0, 1,
                  1,1,'h7010,3,0,0, 1,2,1));
    cyc("ovf7", V(0,0,0,0, 0,0,0,0,0, 1,
                  1,1,'h7018,4,0,0, 1,2,1));
    cyc("ovf8", V(0,0,0,0, 0,0,0,0,0, 1,
                  0,0,0,0,0,0, 1,2,1));

    // wrap: push one and pop one every cycle
    cyc("wrap0", V(0,0,0,0, 1,'h8000,'hC0DE0000,0,0, 1,
                   0,0,0,0,0,0, 1,2,1));
    for (int k = 1; k <= 10; k++) begin
      cyc($sformatf("wrap%0d", k),
          V(0,0,0,0, (k < 10) ? 2'd1 : 2'd0,
            64'h8000 + 64'(8*k), 64'hC0DE0000 + 64'(k), 0,0, 1,
            1,1,64'h8000 + 64'(8*(k-1)),
            64'hC0DE0000 + 64'(k-1),0,0, 1,2,1));
    end
    cyc("wrap_end", V(0,0,0,0, 0,0,0,0,0, 1,
                      0,0,0,0,0,0, 1,2,1));

    // async reset in the middle of a drain
    cyc("mr0", V(0,0,0,0, 2,'h9000,'hA0,'h9008,'hA1, 0,
                 0,0,0,0,0,0, 1,2,1));
    cyc("mr1", V(0,0,0,0, 2,'h9010,'hA2,'h9018,'hA3, 0,
                 1,1,'h9000,'hA0,0,0, 1,2,1));
    cyc("mr2", V(0,0,0,0, 0,0,0,0,0, 0,
                 1,1,'h9000,'hA0,0,0, 1,0,1));
    cyc("mr3", V(0,0,0,0, 0,0,0,0,0, 1,
                 1,1,'h9000,'hA0,0,0, 1,0,1));
    rob_st_retire_num = 0;
    dc_req_ready = 1'b1;
    #2;
    chk("mr_pre valid", 64'(dc_req_valid), 64'd1);
    reset = 1'b0;
    #1;
    check_out("mr_async", idle_exp);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc("mr_rel", idle_exp);
    cyc("mr_idle", idle_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_port_arb.md
Name: dcache_port_arb

Overview:
Arbitrates the single Dcache request port between issued loads from the LSQ and retired stores leaving the store queue head. Holds retired stores in a small post-retire store buffer (SB) so ROB retirement never waits on the cache. Holds one accepted load in a slot and blocks that load while any buffered store has the same 8-byte address. Sits between lsq and the Dcache controller and drives the LSQ's Dcache_avail.

Parameters:
SB_DEPTH, 4, store buffer entries (power of 2, >=2)
SB_BITS, 2, log2(SB_DEPTH)
STARVE_MAX, 8, consecutive load grants allowed while SB is non-empty before a forced drain

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
lsq_rd_mem  in  1  LSQ presents a load this cycle
lsq_addr  in  64  load address
lsq_pr_idx  in  7  load destination PR
lsq_ar_idx  in  5  load destination AR
lsq_dcache_avail  out  1  load slot free; LSQ may present a load
rob_st_retire_num  in  2  stores retiring this cycle (0..2)
st_addr0 / st_value0  in  64/64  oldest retiring store
st_addr1 / st_value1  in  64/64  second retiring store
sb_free  out  2  free SB entries, saturated at 2
sb_overflow  out  1  sticky error: retire exceeded sb_free
dc_req_valid  out  1  request to Dcache
dc_req_wr  out  1  1=store, 0=load
dc_req_addr  out  64  request address
dc_req_value  out  64  store data (0 for loads)
dc_req_pr_idx  out  7  load PR (0 for stores)
dc_req_ar_idx  out  5  load AR (0 for stores)
dc_req_ready  in  1  Dcache accepts the request this cycle

Behaviour:
- Reset (reset=0, async): SB empty, slot empty, state LOAD_PRI, starve_cnt=0, sb_overflow=0. Outputs: dc_req_valid=0, dc_req_wr=0, addr/value/idx=0, lsq_dcache_avail=1, sb_free=2.
- lsq_dcache_avail = ~slot_valid. Registered, with no combinational path from lsq_addr.
- Load accept: if lsq_rd_mem & lsq_dcache_avail, capture addr/pr/ar into the slot at the edge. Earliest Dcache issue is the next cycle (1-cycle latency).
- Retire push: write st0, then st1, at the SB tail. Pointers wrap modulo SB_DEPTH. sb_free is computed from the registered count. If rob_st_retire_num > sb_free, push only sb_free entries and set sb_overflow (sticky until reset).
- Conflict: slot_valid and addr[63:3] equals the addr[63:3] of any valid SB entry.
- Grant is combinational from registered state. A transfer happens when dc_req_valid & dc_req_ready. Outputs hold stable while valid and not ready.
- State LOAD_PRI:
  - slot valid and no conflict: present the load.
  - otherwise, SB non-empty: present the SB head store.
  - On a load transfer with SB non-empty, starve_cnt++.
- State STORE_DRAIN: present only the SB head store.
- Transitions:
  - LOAD_PRI -> STORE_DRAIN when SB count==SB_DEPTH, or starve_cnt==STARVE_MAX, or conflict.
  - STORE_DRAIN -> LOAD_PRI when the SB becomes empty after a pop; starve_cnt cleared.
  - Conflict with SB empty cannot occur.
- Store transfer pops the SB head. Load transfer clears slot_valid.
- A pop and a push in the same cycle are both legal. The count is updated as count + pushes - pop.
- The slot may be refilled on the edge after its transfer.
- An empty SB with an empty slot gives dc_req_valid=0.
- Reset mid-operation discards SB contents and the slot. No write-back is attempted.

Decomposition:
- Shared package lsq_pkg holds:
  - arb_state_t enum: LOAD_PRI, STORE_DRAIN
  - ADDR_CMP_LSB=3
  - DC_ADDR_W=64, PR_W=7, AR_W=5
- Sub-module sb_fifo: SB_DEPTH-entry circular FIFO with 2-wide push, 1 pop, count, and a parallel compare output match_any(addr[63:3]).
- dcache_port_arb instantiates sb_fifo plus the load slot, the FSM and the output mux.

Test Plan:
- Reset then idle: reset low 3 cycles -> dc_req_valid=0, lsq_dcache_avail=1, sb_free=2. Release -> unchanged.
- Load only: present load 0x1000 pr=12 ar=3 in cycle 0, ready=1 -> cycle 1 dc_req_valid=1, wr=0, addr=0x1000, pr=12. Cycle 2 avail=1.
- Conflict stall:
  - Setup: retire store 0x2008 val=0xAB with ready=0, then load 0x200C.
  - Load blocked; state STORE_DRAIN.
  - Set ready=1 -> store issues first (wr=1, value=0xAB), load follows one cycle later.
- Full SB: retire 2+2 stores with ready=0 -> sb_free=0, SB full, STORE_DRAIN. Release ready -> 4 stores drain in FIFO order over 4 cycles, then back to LOAD_PRI.
- Starvation: 1 store buffered, 8 back-to-back non-conflicting loads -> after the 8th load transfer the store issues before load 9.
- Overflow and wrap:
  - With sb_free=1, retire 2 -> one entry stored and sb_overflow=1 (sticky).
  - Run 10 push/pop cycles -> pointers wrap and data order is preserved.
  - Async reset low mid-drain -> dc_req_valid=0 immediately.
